// File: rtl/prio_encoder_hs_if.sv
// Handshake bundle for prio_encoder_hs: request side (in_*) and encoded-result side (out_*).
interface prio_encoder_hs_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] in_req;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_code;
  logic         out_none;
  logic         out_multi;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_req, in_valid, out_ready,
    input  in_ready, out_code, out_none, out_multi, out_valid
  );

  modport slave (
    input  in_req, in_valid, out_ready,
    output in_ready, out_code, out_none, out_multi, out_valid
  );
endinterface

// File: rtl/prio_encoder_hs.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides and a one-entry output register.
// Optional rotating priority enabled by defining PRIO_ENCODER_ROUND_ROBIN_EN; default is fixed highest-index priority.
module prio_encoder_hs #(
  parameter int  N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst_n,
  prio_encoder_hs_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic         in_ready;
  logic         vld_p0;
  logic [W-1:0] code_p0;
  logic         none_p0;
  logic         multi_p0;
  logic [W-1:0] code_p1;
  logic         none_p1;
  logic         multi_p1;
  logic         vld_p1;

  function automatic logic has_multi(input logic [N-1:0] req);
    return (req & (req - N'(1))) != '0;
  endfunction

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
  // Search upward from last+1 with wrap; N is a power of two so W-bit addition wraps mod N.
  function automatic logic [W-1:0] enc_rr(input logic [N-1:0] req, input logic [W-1:0] last);
    logic [W-1:0] code;
    logic [W-1:0] idx;
    logic         found;
    code  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last + k[W-1:0];
      if (!found && req[idx]) begin
        code  = idx;
        found = 1'b1;
      end
    end
    return code;
  endfunction
`else
  function automatic logic [W-1:0] enc_high(input logic [N-1:0] req);
    logic [W-1:0] code;
    code = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) code = i[W-1:0];
    return code;
  endfunction
`endif

  // Stage p0: accept decision and combinational encode of the sampled vector
  assign in_ready = (state_q == EMPTY) || bus.out_ready;
  assign vld_p0   = bus.in_valid && in_ready;
  assign none_p0  = (bus.in_req == '0);
  assign multi_p0 = has_multi(bus.in_req);

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] last_grant_q;

  assign code_p0 = enc_rr(bus.in_req, last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant_q <= W'(N - 1);
    else if (vld_p0 && !none_p0)
      last_grant_q <= code_p0;
  end
`else
  assign code_p0 = enc_high(bus.in_req);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (vld_p0) state_d = FULL;
      FULL:    if (bus.out_ready && !vld_p0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Stage p1: output register, loaded only on accept so it holds under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_p1  <= '0;
      none_p1  <= 1'b0;
      multi_p1 <= 1'b0;
    end else if (vld_p0) begin
      code_p1  <= code_p0;
      none_p1  <= none_p0;
      multi_p1 <= multi_p0;
    end
  end

  assign vld_p1        = (state_q == FULL);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_code  = code_p1;
  assign bus.out_none  = none_p1;
  assign bus.out_multi = multi_p1;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Directed bench for prio_encoder_hs at N=4; expectations follow the build's priority mode.
module tb_prio_encoder_hs;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  prio_encoder_hs_if #(.N(N)) bus ();

  prio_encoder_hs #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int         exp_code;

    bus.in_req    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_code",  32'(bus.out_code), 0);
    chk("rst_none",  32'(bus.out_none), 0);
    chk("rst_multi", 32'(bus.out_multi), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    step();
    step();
    rst_n = 1'b1;

    // Single request on the top line
    bus.in_req    = 4'b1000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_code",  32'(bus.out_code), 3);
    chk("t1_none",  32'(bus.out_none), 0);
    chk("t1_multi", 32'(bus.out_multi), 0);

    // All-zero vector
    bus.in_req = 4'b0000;
    step();
    chk("zero_valid", 32'(bus.out_valid), 1);
    chk("zero_none",  32'(bus.out_none), 1);
    chk("zero_code",  32'(bus.out_code), 0);
    chk("zero_multi", 32'(bus.out_multi), 0);

    // Two requests; zero accept left the rotating pointer at 3
    bus.in_req = 4'b0110;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    exp_code = 1;
`else
    exp_code = 2;
`endif
    step();
    chk("multi_code",  32'(bus.out_code), 32'(exp_code));
    chk("multi_multi", 32'(bus.out_multi), 1);
    chk("multi_none",  32'(bus.out_none), 0);

    // Drain with no new accept: valid drops, data holds
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_code",  32'(bus.out_code), 32'(exp_code));
    chk("drain_in_ready", 32'(bus.in_ready), 1);

    // Back-pressure
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_req    = 4'b0010;
    step();
    chk("bp_first_code", 32'(bus.out_code), 1);
    for (int i = 0; i < 5; i++) begin
      pat = 4'b1000;
      bus.in_req = pat ^ 4'(i);
      step();
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_valid",    32'(bus.out_valid), 1);
      chk("bp_code",     32'(bus.out_code), 1);
      chk("bp_multi",    32'(bus.out_multi), 0);
    end
    bus.in_req    = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("bp_release_valid", 32'(bus.out_valid), 1);
    chk("bp_release_code",  32'(bus.out_code), 2);

    // Streaming walking one
    for (int i = 0; i < 16; i++) begin
      bus.in_req = 4'(1 << (i % 4));
      step();
      chk("stream_valid", 32'(bus.out_valid), 1);
      chk("stream_code",  32'(bus.out_code), 32'(i % 4));
    end

    // All lines requesting for five accepts
    bus.in_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
      exp_code = i % 4;
`else
      exp_code = 3;
`endif
      step();
      chk("all_code",  32'(bus.out_code), 32'(exp_code));
      chk("all_multi", 32'(bus.out_multi), 1);
    end

    // Asynchronous reset mid-transaction
    bus.out_ready = 1'b0;
    bus.in_req    = 4'b0001;
    step();
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_code",  32'(bus.out_code), 0);
    chk("async_rst_multi", 32'(bus.out_multi), 0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 1);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_req    = 4'b1111;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    exp_code = 0;
`else
    exp_code = 3;
`endif
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_code",  32'(bus.out_code), 32'(exp_code));

    bus.in_valid = 1'b0;
    step();
    chk("final_valid", 32'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
